// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - 5-stage pipeline stall/flush sequencer with memory wait, timeout and counters
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_memRead,
    input  logic [4:0]       idex_rt,
    input  logic [1:0]       PCsrc,
    input  logic             exmem_memRead,
    input  logic             exmem_memWrite,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mem_err_nxt;

    logic mem_access;
    logic load_use;
    logic released;

    assign mem_access = exmem_memRead | exmem_memWrite;
    assign load_use   = idex_memRead && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // Pipeline may advance this cycle: RUN without a pending miss, or the wait just completed.
    always_comb begin
        released = 1'b0;
        case (state)
            RUN:      released = !(mem_access && !mem_ready);
            MEM_WAIT: released = mem_ready;
            default:  released = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        case (state)
            RUN: begin
                if (mem_access && !mem_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_MAX) begin
                    state_nxt   = ERROR;
                    mem_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = ERROR;
        endcase
    end

    // Everything is forced inactive while reset is held so an aborted access issues nothing.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        mem_req     = 1'b0;
        if (rst_n) begin
            case (state)
                RUN:      mem_req = mem_access;
                MEM_WAIT: mem_req = 1'b1;
                default:  mem_req = 1'b0;
            endcase
            if (released) begin
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                if (load_use) begin
                    idex_flush = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = (PCsrc != 2'd0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (ifid_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed and randomized checks of hazard_stall_ctrl against a cycle model
module tb_hazard_stall_ctrl;

    localparam int MT  = 4;
    localparam int CW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic          ifid_uses_rt = 1'b0, idex_memRead = 1'b0;
    logic [1:0]    PCsrc = '0;
    logic          exmem_memRead = 1'b0, exmem_memWrite = 1'b0, mem_ready = 1'b0, cnt_clr = 1'b0;
    logic          pc_write, ifid_write, idex_write, exmem_write;
    logic          ifid_flush, idex_flush, mem_req, mem_err;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [6:0]    outs;

    int checks = 0;
    int errors = 0;

    int m_busy;
    bit m_err;
    int m_stall, m_flush;

    hazard_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_memRead(idex_memRead), .idex_rt(idex_rt), .PCsrc(PCsrc),
        .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .mem_req(mem_req), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, mem_req}
    assign outs = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, mem_req};

    // Model: a memory access is "outstanding" for m_busy consecutive un-ready cycles;
    // more than MT of them is a timeout.
    function automatic logic [6:0] model_outs();
        logic acc, req, lu;
        if (!rst_n || m_err) return 7'b0;
        acc = exmem_memRead | exmem_memWrite;
        req = acc | (m_busy > 0);
        if ((acc || m_busy > 0) && !mem_ready) return {6'b0, req};
        lu = idex_memRead && idex_rt != 0 &&
             (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
        if (lu) return {4'b0011, 2'b01, req};
        if (PCsrc != 0) return {4'b1111, 2'b10, req};
        return {4'b1111, 2'b00, req};
    endfunction

    task automatic model_clear();
        m_busy = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic tick();
        logic [6:0] e;
        logic acc;
        e = model_outs();
        acc = exmem_memRead | exmem_memWrite;
        @(posedge clk);
        if (rst_n) begin
            if (cnt_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e[6] && m_stall < SAT) m_stall++;
                if (e[2] && m_flush < SAT) m_flush++;
            end
            if (!m_err) begin
                if ((acc || m_busy > 0) && !mem_ready) begin
                    m_busy++;
                    if (m_busy == MT + 1) m_err = 1;
                end else begin
                    m_busy = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        ifid_rs = 0; ifid_rt = 0; idex_rt = 0; ifid_uses_rt = 0; idex_memRead = 0;
        PCsrc = 0; exmem_memRead = 0; exmem_memWrite = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_clear();
        exmem_memRead = 1; PCsrc = 1; idex_memRead = 1; idex_rt = 3; ifid_rs = 3;
        #1;
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, 7'b0); end
        checks++;
        if (stall_cycles !== 0 || flush_count !== 0 || mem_err !== 0) begin
            errors++;
            $display("FAIL reset_state got stall=%0d flush=%0d err=%b exp 0 0 0", stall_cycles, flush_count, mem_err);
        end
        do_reset();
        #1;
        checks++;
        if (outs !== 7'b1111000) begin errors++; $display("FAIL reset_release got %b exp %b", outs, 7'b1111000); end
    endtask

    task automatic test_load_use();
        do_reset();
        idex_memRead = 1; idex_rt = 2; ifid_rs = 2; ifid_rt = 4; ifid_uses_rt = 1;
        #1;
        checks++;
        if (outs !== 7'b0011010) begin errors++; $display("FAIL load_use_stall got %b exp %b", outs, 7'b0011010); end
        tick();
        idex_memRead = 0; idex_rt = 0;
        #1;
        checks++;
        if (outs !== 7'b1111000) begin errors++; $display("FAIL load_use_after got %b exp %b", outs, 7'b1111000); end
        tick();
        checks++;
        if (stall_cycles !== 1) begin errors++; $display("FAIL load_use_count got %0d exp 1", stall_cycles); end
        idex_memRead = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        #1;
        checks++;
        if (outs !== 7'b1111000) begin errors++; $display("FAIL rt_zero got %b exp %b", outs, 7'b1111000); end
        tick();
        idex_rt = 7; ifid_rs = 1; ifid_rt = 7; ifid_uses_rt = 0;
        #1;
        checks++;
        if (outs !== 7'b1111000) begin errors++; $display("FAIL rt_unused got %b exp %b", outs, 7'b1111000); end
        ifid_uses_rt = 1;
        #1;
        checks++;
        if (outs !== 7'b0011010) begin errors++; $display("FAIL rt_used got %b exp %b", outs, 7'b0011010); end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        for (int s = 1; s <= 2; s++) begin
            PCsrc = 2'(s);
            #1;
            checks++;
            if (outs !== 7'b1111100) begin errors++; $display("FAIL branch_flush src=%0d got %b exp %b", s, outs, 7'b1111100); end
            tick();
            PCsrc = 0;
            #1;
            checks++;
            if (outs !== 7'b1111000) begin errors++; $display("FAIL branch_after src=%0d got %b exp %b", s, outs, 7'b1111000); end
            tick();
            checks++;
            if (flush_count !== CW'(s)) begin errors++; $display("FAIL branch_count got %0d exp %0d", flush_count, s); end
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        exmem_memWrite = 1; mem_ready = 1;
        #1;
        checks++;
        if (outs !== 7'b1111001) begin errors++; $display("FAIL mem_zero_wait got %b exp %b", outs, 7'b1111001); end
        tick();
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== 7'b0000001) begin errors++; $display("FAIL mem_frozen cyc=%0d got %b exp %b", i, outs, 7'b0000001); end
            tick();
        end
        mem_ready = 1;
        #1;
        checks++;
        if (outs !== 7'b1111001) begin errors++; $display("FAIL mem_release got %b exp %b", outs, 7'b1111001); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (outs !== 7'b1111000 || stall_cycles !== 3) begin
            errors++;
            $display("FAIL mem_done got outs=%b stall=%0d exp %b 3", outs, stall_cycles, 7'b1111000);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        exmem_memRead = 1; mem_ready = 0;
        for (int i = 0; i < MT + 1; i++) begin
            #1;
            checks++;
            if (outs !== 7'b0000001 || mem_err !== 0) begin
                errors++;
                $display("FAIL timeout_wait cyc=%0d got outs=%b err=%b exp %b 0", i, outs, mem_err, 7'b0000001);
            end
            tick();
        end
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== 7'b0 || mem_err !== 1) begin
                errors++;
                $display("FAIL timeout_error cyc=%0d got outs=%b err=%b exp %b 1", i, outs, mem_err, 7'b0);
            end
            tick();
        end
        checks++;
        if (stall_cycles !== CW'(MT + 4)) begin errors++; $display("FAIL timeout_count got %0d exp %0d", stall_cycles, MT + 4); end
        do_reset();
        #1;
        checks++;
        if (outs !== 7'b1111000 || mem_err !== 0 || stall_cycles !== 0) begin
            errors++;
            $display("FAIL timeout_recover got outs=%b err=%b stall=%0d exp %b 0 0", outs, mem_err, stall_cycles, 7'b1111000);
        end
        exmem_memRead = 1; mem_ready = 0;
        tick(); tick();
        rst_n = 0; model_clear();
        #1;
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL reset_abort got %b exp %b", outs, 7'b0); end
        do_reset();
    endtask

    task automatic test_priority_sat();
        do_reset();
        idex_memRead = 1; idex_rt = 5; ifid_rs = 5; PCsrc = 1;
        #1;
        checks++;
        if (outs !== 7'b0011010) begin errors++; $display("FAIL stall_over_branch got %b exp %b", outs, 7'b0011010); end
        tick();
        checks++;
        if (flush_count !== 0 || stall_cycles !== 1) begin
            errors++;
            $display("FAIL stall_over_branch_cnt got flush=%0d stall=%0d exp 0 1", flush_count, stall_cycles);
        end
        idex_memRead = 0;
        repeat (SAT + 5) tick();
        checks++;
        if (flush_count !== CW'(SAT)) begin errors++; $display("FAIL flush_saturate got %0d exp %0d", flush_count, SAT); end
        PCsrc = 0; exmem_memWrite = 1; mem_ready = 0;
        repeat (SAT + 5) tick();
        checks++;
        if (stall_cycles !== CW'(SAT)) begin errors++; $display("FAIL stall_saturate got %0d exp %0d", stall_cycles, SAT); end
        cnt_clr = 1;
        tick();
        checks++;
        if (stall_cycles !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL cnt_clr got stall=%0d flush=%0d exp 0 0", stall_cycles, flush_count);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 0;
                model_clear();
            end else begin
                rst_n = 1;
            end
            ifid_rs        = 5'($urandom_range(0, 3));
            ifid_rt        = 5'($urandom_range(0, 3));
            idex_rt        = 5'($urandom_range(0, 3));
            ifid_uses_rt   = 1'($urandom);
            idex_memRead   = 1'($urandom);
            PCsrc          = 2'($urandom);
            exmem_memRead  = ($urandom_range(0, 3) == 0);
            exmem_memWrite = ($urandom_range(0, 3) == 0);
            mem_ready      = ($urandom_range(0, 9) < 6);
            cnt_clr        = ($urandom_range(0, 49) == 0);
            #1;
            e = model_outs();
            checks++;
            if (outs !== e) begin errors++; $display("FAIL rand_outs i=%0d got %b exp %b", i, outs, e); end
            checks++;
            if (stall_cycles !== CW'(m_stall) || flush_count !== CW'(m_flush) || mem_err !== m_err) begin
                errors++;
                $display("FAIL rand_state i=%0d got stall=%0d flush=%0d err=%b exp %0d %0d %b",
                         i, stall_cycles, flush_count, mem_err, m_stall, m_flush, m_err);
            end
            tick();
        end
        rst_n = 1;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_priority_sat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
